// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped instruction cache controller: combinational hit lookup,
// single-beat-outstanding line refill, flush and saturating hit/miss counters.
module icache_fetch_ctrl #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cpu_req_i,
    input  logic [31:0]      cpu_addr_i,
    output logic [31:0]      cpu_inst_o,
    output logic             cpu_hit_o,
    output logic             cpu_stall_o,
    input  logic             flush_i,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int unsigned BW = $clog2(WORDS);
    localparam int unsigned OB = BW + 2;
    localparam int unsigned IB = $clog2(LINES);
    localparam int unsigned TW = 32 - OB - IB;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_e;

    state_e           state_q, state_d;
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];
    logic [31:0]      base_q;
    logic [BW-1:0]    beat_q;
    logic             flush_pend_q;
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

    logic [BW-1:0]    cpu_word;
    logic [IB-1:0]    cpu_idx, fill_idx;
    logic [TW-1:0]    cpu_tag;
    logic             hit_c;
    logic             miss, data_we, beat_inc, set_valid, clr_valid;
    logic             unused_addr_bits;

    assign cpu_word         = cpu_addr_i[OB-1:2];
    assign cpu_idx          = cpu_addr_i[OB+IB-1:OB];
    assign cpu_tag          = cpu_addr_i[31:OB+IB];
    assign fill_idx         = base_q[OB+IB-1:OB];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // Zero-latency lookup; only IDLE may report a hit
    assign hit_c       = cpu_req_i && (state_q == IDLE) && valid_q[cpu_idx]
                         && (tag_q[cpu_idx] == cpu_tag);
    assign cpu_hit_o   = hit_c;
    assign cpu_inst_o  = hit_c ? data_q[cpu_idx][cpu_word] : 32'h0;
    assign cpu_stall_o = cpu_req_i & ~hit_c;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        miss       = 1'b0;
        data_we    = 1'b0;
        beat_inc   = 1'b0;
        set_valid  = 1'b0;
        clr_valid  = 1'b0;
        mem_req_o  = 1'b0;
        mem_addr_o = 32'h0;
        case (state_q)
            IDLE: begin
                clr_valid = flush_i;
                if (cpu_req_i && !hit_c) begin
                    miss    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base_q + 32'({beat_q, 2'b00});
                if (mem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    data_we = 1'b1;
                    if (beat_q == BW'(WORDS - 1)) begin
                        state_d = FILL;
                    end else begin
                        beat_inc = 1'b1;
                        state_d  = REQ;
                    end
                end
            end
            FILL: begin
                state_d = IDLE;
                // A flush seen during the refill wins over installing the line
                if (flush_pend_q || flush_i) clr_valid = 1'b1;
                else                         set_valid = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            base_q       <= 32'h0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clr_valid)      valid_q           <= '0;
            else if (set_valid) valid_q[fill_idx] <= 1'b1;
            if (miss) begin
                base_q <= {cpu_addr_i[31:OB], OB'(0)};
                beat_q <= '0;
            end else if (beat_inc) begin
                beat_q <= beat_q + BW'(1);
            end
            if (state_q == FILL)                  flush_pend_q <= 1'b0;
            else if (state_q != IDLE && flush_i)  flush_pend_q <= 1'b1;
            if (hit_c && hit_cnt_q != '1)  hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
            if (miss && miss_cnt_q != '1)  miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    // Tag and data storage carry no reset; valid bits guard them
    always_ff @(posedge clk_i) begin
        if (data_we)   data_q[fill_idx][beat_q] <= mem_rdata_i;
        if (set_valid) tag_q[fill_idx]          <= base_q[31:OB+IB];
    end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Bench for icache_fetch_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a line-level cache model and a fixed memory image.
module tb_icache_fetch_ctrl;

    localparam int unsigned LINES = 16;
    localparam int unsigned WORDS = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OB    = 4;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic             clk_i;
    logic             rst_i;
    logic             cpu_req_i;
    logic [31:0]      cpu_addr_i;
    logic [31:0]      cpu_inst_o;
    logic             cpu_hit_o;
    logic             cpu_stall_o;
    logic             flush_i;
    logic             mem_req_o;
    logic [31:0]      mem_addr_o;
    logic             mem_gnt_i;
    logic             mem_rvalid_i;
    logic [31:0]      mem_rdata_i;
    logic [CNT_W-1:0] hit_cnt_o;
    logic [CNT_W-1:0] miss_cnt_o;

    icache_fetch_ctrl #(.LINES(LINES), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_inst_o(cpu_inst_o),
        .cpu_hit_o(cpu_hit_o), .cpu_stall_o(cpu_stall_o), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Cache model: which line address each index holds, plus refill progress
    bit          mval [LINES];
    logic [31:0] mline [LINES];
    bit          busy, outst, fill_cyc, fpend;
    int          beats;
    logic [31:0] pend;
    int          hc, mc;
    int          gnt_left, rv_left, gnt_fix, rv_fix;
    logic [31:0] gnt_log [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'h0010_0053 + (a >> 2);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(WORDS * 4 - 1);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> OB) % 32'(LINES));
    endfunction

    function automatic int pick_gnt();
        return (gnt_fix >= 0) ? gnt_fix : int'($urandom_range(0, 3));
    endfunction

    function automatic int pick_lat();
        return (rv_fix >= 1) ? rv_fix : int'($urandom_range(1, 5));
    endfunction

    task automatic model_reset();
        foreach (mval[i]) mval[i] = 1'b0;
        busy = 0; outst = 0; fill_cyc = 0; fpend = 0; beats = 0; pend = 32'h0;
        hc = 0; mc = 0; gnt_left = 0; rv_left = 0;
    endtask

    task automatic idle_inputs();
        cpu_req_i = 1'b0; cpu_addr_i = 32'h0; flush_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One clock: memory responds from the model, outputs checked, model advanced
    task automatic cycle(input logic req, input logic [31:0] addr, input logic flush, input logic stray);
        logic        e_req, e_hit;
        logic [31:0] e_addr, e_inst;
        int          idx;
        @(negedge clk_i);
        e_req        = busy && !outst && !fill_cyc;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        if (e_req) begin
            if (gnt_left == 0) mem_gnt_i = 1'b1;
            else gnt_left--;
        end
        if (busy && outst) begin
            if (rv_left == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_val(pend + 32'(4 * beats));
            end else begin
                rv_left--;
            end
        end else begin
            mem_rvalid_i = stray;
        end
        cpu_req_i  = req;
        cpu_addr_i = addr;
        flush_i    = flush;
        #1;
        idx    = idx_of(addr);
        e_hit  = !busy && req && mval[idx] && (mline[idx] == line_of(addr));
        e_inst = e_hit ? mem_val(addr) : 32'h0;
        e_addr = e_req ? pend + 32'(4 * beats) : 32'h0;
        check_eq("hit", 32'(cpu_hit_o), 32'(e_hit));
        check_eq("inst", cpu_inst_o, e_inst);
        check_eq("stall", 32'(cpu_stall_o), 32'(req & ~e_hit));
        check_eq("mem_req", 32'(mem_req_o), 32'(e_req));
        check_eq("mem_addr", mem_addr_o, e_addr);
        check_eq("hit_cnt", 32'(hit_cnt_o), 32'(hc));
        check_eq("miss_cnt", 32'(miss_cnt_o), 32'(mc));
        if (mem_gnt_i) gnt_log.push_back(mem_addr_o);
        if (!busy) begin
            if (req && !e_hit) begin
                if (mc < SAT) mc++;
                busy = 1; pend = line_of(addr); beats = 0;
                outst = 0; fill_cyc = 0; fpend = 0; gnt_left = pick_gnt();
            end
            if (flush) foreach (mval[i]) mval[i] = 1'b0;
        end else if (fill_cyc) begin
            if (fpend || flush) begin
                foreach (mval[i]) mval[i] = 1'b0;
            end else begin
                mval[idx_of(pend)]  = 1'b1;
                mline[idx_of(pend)] = pend;
            end
            busy = 0; fill_cyc = 0;
        end else begin
            if (flush) fpend = 1;
            if (e_req && mem_gnt_i) begin
                outst = 1; rv_left = pick_lat() - 1;
            end else if (outst && mem_rvalid_i) begin
                outst = 0; beats++;
                if (beats == int'(WORDS)) fill_cyc = 1;
                else gnt_left = pick_gnt();
            end
        end
        if (e_hit && hc < SAT) hc++;
    endtask

    task automatic run_until_hit(input logic [31:0] addr, output int n);
        bit got;
        got = 0;
        n   = 0;
        for (int k = 0; k < 500 && !got; k++) begin
            cycle(1'b1, addr, 1'b0, 1'b0);
            if (cpu_hit_o) got = 1;
            else n++;
        end
        if (!got) check_eq("hit_timeout", 32'(n), 32'(-1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int n;
        gnt_fix = 0; rv_fix = 1;
        rst_i = 1'b1;
        idle_inputs();
        cpu_req_i = 1'b1; cpu_addr_i = 32'h100;
        model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        check_eq("rst_hit", 32'(cpu_hit_o), 32'd0);
        check_eq("rst_stall", 32'(cpu_stall_o), 32'd1);
        check_eq("rst_mem_req", 32'(mem_req_o), 32'd0);
        check_eq("rst_mem_addr", mem_addr_o, 32'h0);
        check_eq("rst_cnts", 32'({hit_cnt_o, miss_cnt_o}), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_inputs();

        // Cold miss on 0x100 with single-cycle handshakes
        gnt_log.delete();
        run_until_hit(32'h100, n);
        check_eq("penalty", 32'(n), 32'd10);
        check_eq("first_inst", cpu_inst_o, 32'h0010_0093);
        check_eq("beat_count", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_eq("beat_addr", gnt_log[i], 32'h100 + 32'(4 * i));
        cycle(1'b1, 32'h108, 1'b0, 1'b0);
        check_eq("hit_108", 32'(cpu_hit_o), 32'd1);
        check_eq("inst_108", cpu_inst_o, 32'h0010_0095);
        check_eq("miss_cnt_1", 32'(miss_cnt_o), 32'd1);

        // Conflict at index 0
        do_reset();
        run_until_hit(32'h000, n);
        check_eq("conf_inst_a", cpu_inst_o, 32'h0010_0053);
        run_until_hit(32'h100, n);
        check_eq("conf_inst_b", cpu_inst_o, 32'h0010_0093);
        run_until_hit(32'h000, n);
        check_eq("conf_inst_c", cpu_inst_o, 32'h0010_0053);
        check_eq("conf_miss_cnt", 32'(miss_cnt_o), 32'd3);

        // Flush while waiting for beat 1 of 0x200
        rv_fix = 3;
        gnt_log.delete();
        for (int k = 0; k < 100 && !(busy && beats == 1 && outst); k++)
            cycle(1'b1, 32'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'h200, 1'b1, 1'b0);
        for (int k = 0; k < 100 && busy; k++) cycle(1'b1, 32'h200, 1'b0, 1'b0);
        check_eq("flush_beats", 32'(gnt_log.size()), 32'd4);
        cycle(1'b1, 32'h200, 1'b0, 1'b0);
        check_eq("flush_remiss", 32'(cpu_hit_o), 32'd0);
        run_until_hit(32'h200, n);

        // Slow memory: gnt after 3 cycles, rvalid 5 cycles after gnt
        gnt_fix = 3; rv_fix = 5;
        run_until_hit(32'h500, n);
        check_eq("slow_stall_cycles", 32'(n), 32'd38);
        check_eq("slow_inst", cpu_inst_o, mem_val(32'h500));

        // Asynchronous reset during beat 2 of a refill, then a stray rvalid
        gnt_fix = 0; rv_fix = 4;
        run_until_hit(32'h300, n);
        for (int k = 0; k < 100 && !(busy && beats == 2 && outst); k++)
            cycle(1'b1, 32'h400, 1'b0, 1'b0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("arst_mem_req", 32'(mem_req_o), 32'd0);
        check_eq("arst_stall", 32'(cpu_stall_o), 32'(cpu_req_i));
        check_eq("arst_cnts", 32'({hit_cnt_o, miss_cnt_o}), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_inputs();
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("stray_miss_cnt", 32'(miss_cnt_o), 32'd0);
        cycle(1'b1, 32'h300, 1'b0, 1'b0);
        check_eq("arst_lost_line", 32'(cpu_hit_o), 32'd0);
        run_until_hit(32'h300, n);

        // Hit counter saturation
        rv_fix = 1;
        do_reset();
        run_until_hit(32'h100, n);
        repeat (20) cycle(1'b1, 32'h104, 1'b0, 1'b0);
        check_eq("hit_sat", 32'(hit_cnt_o), 32'd15);

        // Random traffic over a small address pool
        gnt_fix = -1; rv_fix = -1;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3))
              | (32'($urandom_range(0, 1)) << 31);
            cycle($urandom_range(0, 9) < 8, a, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
